// File: rtl/micro_sequencer_pkg.sv
// Shared types, AHB constants and the default microcode image for the
// microcoded RV32 control sequencer.
package micro_pkg;

  localparam int CTRL_W_DEF    = 20;
  localparam int UADDR_W_DEF   = 5;
  localparam int ROM_DEPTH_DEF = 28;

  typedef enum logic [1:0] {
    AHB_NONE  = 2'b00,
    AHB_READ  = 2'b01,
    AHB_WRITE = 2'b10
  } ahb_op_e;

  // Bit 0 of ctrl is the last-step flag.
  typedef struct packed {
    ahb_op_e                 ahb_op;
    logic                    wait_rdy;
    logic [CTRL_W_DEF-1:0]   ctrl;
  } micro_word_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int UA_LW   = 0;
  localparam int UA_SW   = 2;
  localparam int UA_ADD  = 4;
  localparam int UA_JAL  = 14;
  localparam int UA_WAIT = 18;
  localparam int UA_BNE  = 19;
  localparam int UA_BLTU = 21;
  localparam int UA_SUB  = 24;

  // NOTE: the microcode is a constant table, not storage, so it has no reset.
  localparam micro_word_t MICROCODE [ROM_DEPTH_DEF] = '{
    '{AHB_READ,  1'b1, 20'h01020},  // 0  LW address phase
    '{AHB_NONE,  1'b1, 20'h02041},  // 1  LW data phase, last
    '{AHB_WRITE, 1'b1, 20'h01030},  // 2  SW address phase
    '{AHB_NONE,  1'b1, 20'h04001},  // 3  SW data phase, last
    '{AHB_NONE,  1'b0, 20'h10101},  // 4  ADD
    '{AHB_NONE,  1'b0, 20'h10201},  // 5  SLL
    '{AHB_NONE,  1'b0, 20'h10301},  // 6  SLT
    '{AHB_NONE,  1'b0, 20'h10401},  // 7  SLTU
    '{AHB_NONE,  1'b0, 20'h10501},  // 8  XOR
    '{AHB_NONE,  1'b0, 20'h10601},  // 9  SRL
    '{AHB_NONE,  1'b0, 20'h10701},  // 10 SRA
    '{AHB_NONE,  1'b0, 20'h10801},  // 11 OR
    '{AHB_NONE,  1'b0, 20'h10901},  // 12 AND
    '{AHB_NONE,  1'b0, 20'h20001},  // 13 LUI
    '{AHB_NONE,  1'b0, 20'h40010},  // 14 JAL: link
    '{AHB_NONE,  1'b0, 20'h40020},  // 15 JAL: target add
    '{AHB_NONE,  1'b0, 20'h40040},  // 16 JAL: pc load
    '{AHB_NONE,  1'b0, 20'h48001},  // 17 JAL: writeback, last
    '{AHB_NONE,  1'b0, 20'h80000},  // 18 WAIT / idle
    '{AHB_NONE,  1'b0, 20'h00110},  // 19 BNE: compare
    '{AHB_NONE,  1'b0, 20'h00221},  // 20 BNE: branch, last
    '{AHB_NONE,  1'b0, 20'h00310},  // 21 BLTU: compare
    '{AHB_NONE,  1'b0, 20'h00320},  // 22 BLTU: target add
    '{AHB_NONE,  1'b0, 20'h00421},  // 23 BLTU: branch, last
    '{AHB_NONE,  1'b0, 20'h10a01},  // 24 SUB
    '{AHB_NONE,  1'b0, 20'h20101},  // 25 AUIPC
    '{AHB_NONE,  1'b0, 20'h40110},  // 26 JALR: target add
    '{AHB_NONE,  1'b0, 20'h48101}   // 27 JALR: writeback, last
  };

endpackage

// File: rtl/micro_sequencer_if.sv
// Sequencer-side bundle: decoder hand-off, AHB master controls and datapath
// control/status. The sequencer uses the slave view.
interface micro_sequencer_if #(
  parameter int CTRL_W  = 20,
  parameter int UADDR_W = 5
);

  logic [UADDR_W-1:0] decode_addr;
  logic               id_rf_valid_inst;
  logic               HREADY;
  logic               HRESP;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [CTRL_W-1:0]  current_control;
  logic               done;
  logic               rf_valid_inst;
  logic               busy;
  logic               error;

  modport master (
    output decode_addr, id_rf_valid_inst, HREADY, HRESP,
    input  HTRANS, HWRITE, current_control, done, rf_valid_inst, busy, error
  );

  modport slave (
    input  decode_addr, id_rf_valid_inst, HREADY, HRESP,
    output HTRANS, HWRITE, current_control, done, rf_valid_inst, busy, error
  );

endinterface

// File: rtl/micro_sequencer_rom.sv
// Combinational microcode lookup; out-of-range addresses return the wait word
// and flag o_oob so the sequencer can report an illegal uPC.
module micro_rom
  import micro_pkg::*;
#(
  parameter int UADDR_W   = 5,
  parameter int ROM_DEPTH = 28,
  parameter int WAIT_ADDR = UA_WAIT
) (
  input  logic [UADDR_W-1:0] i_addr,
  output micro_word_t        o_word,
  output logic               o_oob
);

  always_comb begin
    // NOTE: default first so every path assigns o_word; no latch is inferred.
    o_word = MICROCODE[WAIT_ADDR];
    o_oob  = int'(i_addr) >= ROM_DEPTH;
    if (!o_oob) begin
      o_word = MICROCODE[i_addr];
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microcoded control sequencer: explicit uPC, per-word AHB op / wait-on-HREADY /
// last-step sequencing, with bus-error and illegal-uPC termination.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int CTRL_W    = 20,
  parameter int UADDR_W   = 5,
  parameter int ROM_DEPTH = 28,
  parameter int WAIT_ADDR = 18
) (
  input  logic               clk,
  input  logic               rst,
  micro_sequencer_if.slave   bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [UADDR_W-1:0] WAIT_UA   = UADDR_W'(WAIT_ADDR);
  localparam logic [CTRL_W-1:0]  WAIT_CTRL = CTRL_W'(MICROCODE[WAIT_ADDR].ctrl);

  logic [0:0]         r_state;
  logic [UADDR_W-1:0] r_upc;

  logic [UADDR_W-1:0] w_fetch_addr;
  logic [UADDR_W-1:0] w_next_upc;
  micro_word_t        w_word;
  logic               w_oob;
  logic [CTRL_W-1:0]  w_ctrl;
  logic               w_last;
  logic               w_adv;
  logic               w_active;
  logic               w_bus_err;
  logic               w_overflow;
  logic               w_error;
  logic               w_done;

  always_comb begin
    w_fetch_addr = WAIT_UA;
    if (r_state == ST_RUN) begin
      w_fetch_addr = r_upc;
    end else if (bus.id_rf_valid_inst) begin
      w_fetch_addr = bus.decode_addr;
    end
  end

  micro_rom #(
    .UADDR_W   (UADDR_W),
    .ROM_DEPTH (ROM_DEPTH),
    .WAIT_ADDR (WAIT_ADDR)
  ) u_rom (
    .i_addr (w_fetch_addr),
    .o_word (w_word),
    .o_oob  (w_oob)
  );

  assign w_ctrl     = CTRL_W'(w_word.ctrl);
  assign w_last     = w_ctrl[0];
  assign w_adv      = !(w_word.wait_rdy && !bus.HREADY);
  assign w_active   = rst && bus.id_rf_valid_inst;
  assign w_next_upc = w_fetch_addr + 1'b1;

  // Stepping past the last implemented word is illegal rather than wrapping.
  assign w_overflow = w_adv && !w_last && (int'(w_fetch_addr) + 1 >= ROM_DEPTH);
  assign w_bus_err  = w_word.wait_rdy && bus.HREADY && bus.HRESP;
  assign w_error    = w_active && (w_bus_err || w_oob || w_overflow);
  assign w_done     = w_active && w_last && w_adv && !w_error;

  assign bus.HTRANS          = (w_active && (w_word.ahb_op != AHB_NONE)) ? HTRANS_NONSEQ
                                                                         : HTRANS_IDLE;
  assign bus.HWRITE          = w_active && (w_word.ahb_op == AHB_WRITE);
  assign bus.current_control = rst ? w_ctrl : WAIT_CTRL;
  assign bus.done            = w_done;
  assign bus.rf_valid_inst   = w_done || w_error;
  assign bus.busy            = rst && (r_state == ST_RUN);
  assign bus.error           = w_error;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      r_state <= ST_IDLE;
      r_upc   <= WAIT_UA;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A stalled first word is replayed from RUN at the same address.
          if (w_active && !w_error && !(w_adv && w_last)) begin
            r_state <= ST_RUN;
            r_upc   <= w_adv ? w_next_upc : w_fetch_addr;
          end
        end
        ST_RUN: begin
          if (!w_active || w_error || (w_adv && w_last)) begin
            r_state <= ST_IDLE;
            r_upc   <= WAIT_UA;
          end else if (w_adv) begin
            r_upc <= w_next_upc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_upc   <= WAIT_UA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: reset, single/multi-word instructions,
// HREADY stalls, bus error, abort, illegal address and reset mid-instruction.
module tb_micro_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  micro_sequencer_if #(.CTRL_W(20), .UADDR_W(5)) bus ();

  micro_sequencer #(
    .CTRL_W    (20),
    .UADDR_W   (5),
    .ROM_DEPTH (28),
    .WAIT_ADDR (18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst                  = 1'b0;
    bus.decode_addr      = 5'd0;
    bus.id_rf_valid_inst = 1'b1;
    bus.HREADY           = 1'b1;
    bus.HRESP            = 1'b0;

    // Reset held for three cycles with a valid LW presented
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_htrans", bus.HTRANS, 32'h0);
      check("rst_rfvalid", bus.rf_valid_inst, 32'h0);
      check("rst_busy", bus.busy, 32'h0);
    end
    check("rst_ctrl", bus.current_control, 32'h80000);
    check("rst_hwrite", bus.HWRITE, 32'h0);
    rst = 1'b1;
    bus.id_rf_valid_inst = 1'b0;
    settle();
    check("post_rst_upc", dut.r_upc, 32'd18);
    check("post_rst_busy", bus.busy, 32'h0);
    check("idle_ctrl", bus.current_control, 32'h80000);

    // ADD: single-step, completes in IDLE
    bus.decode_addr = 5'd4;
    bus.id_rf_valid_inst = 1'b1;
    settle();
    check("add_htrans", bus.HTRANS, 32'h0);
    check("add_done", bus.done, 32'h1);
    check("add_rfvalid", bus.rf_valid_inst, 32'h1);
    check("add_ctrl", bus.current_control, 32'h10101);
    tick();
    check("add_busy", bus.busy, 32'h0);

    // LW with HREADY=1: two cycles
    bus.decode_addr = 5'd0;
    settle();
    check("lw_c0_htrans", bus.HTRANS, 32'h2);
    check("lw_c0_hwrite", bus.HWRITE, 32'h0);
    check("lw_c0_done", bus.done, 32'h0);
    tick();
    check("lw_c1_busy", bus.busy, 32'h1);
    check("lw_c1_ctrl", bus.current_control, 32'h02041);
    check("lw_c1_done", bus.done, 32'h1);
    check("lw_c1_htrans", bus.HTRANS, 32'h0);
    tick();
    check("lw_end_busy", bus.busy, 32'h0);

    // SW with two wait states in the address phase
    bus.decode_addr = 5'd2;
    bus.HREADY = 1'b0;
    settle();
    check("sw_c0_htrans", bus.HTRANS, 32'h2);
    check("sw_c0_hwrite", bus.HWRITE, 32'h1);
    check("sw_c0_done", bus.done, 32'h0);
    tick();
    check("sw_c1_upc", dut.r_upc, 32'd2);
    check("sw_c1_htrans", bus.HTRANS, 32'h2);
    check("sw_c1_hwrite", bus.HWRITE, 32'h1);
    tick();
    bus.HREADY = 1'b1;
    settle();
    check("sw_c2_upc", dut.r_upc, 32'd2);
    check("sw_c2_htrans", bus.HTRANS, 32'h2);
    check("sw_c2_hwrite", bus.HWRITE, 32'h1);
    check("sw_c2_done", bus.done, 32'h0);
    tick();
    check("sw_c3_done", bus.done, 32'h1);
    check("sw_c3_ctrl", bus.current_control, 32'h04001);
    check("sw_c3_htrans", bus.HTRANS, 32'h0);
    tick();
    check("sw_end_busy", bus.busy, 32'h0);

    // LW with HRESP error in the data phase
    bus.decode_addr = 5'd0;
    settle();
    check("lwe_c0_htrans", bus.HTRANS, 32'h2);
    tick();
    bus.HRESP = 1'b1;
    settle();
    check("lwe_error", bus.error, 32'h1);
    check("lwe_rfvalid", bus.rf_valid_inst, 32'h1);
    check("lwe_done", bus.done, 32'h0);
    tick();
    bus.HRESP = 1'b0;
    bus.id_rf_valid_inst = 1'b0;
    settle();
    check("lwe_after_busy", bus.busy, 32'h0);
    check("lwe_after_htrans", bus.HTRANS, 32'h0);
    check("lwe_after_error", bus.error, 32'h0);

    // BLTU aborted by dropping valid after one cycle
    bus.decode_addr = 5'd21;
    bus.id_rf_valid_inst = 1'b1;
    settle();
    check("bltu_c0_ctrl", bus.current_control, 32'h00310);
    check("bltu_c0_done", bus.done, 32'h0);
    tick();
    check("bltu_c1_busy", bus.busy, 32'h1);
    check("bltu_c1_ctrl", bus.current_control, 32'h00320);
    bus.id_rf_valid_inst = 1'b0;
    settle();
    check("abort_rfvalid", bus.rf_valid_inst, 32'h0);
    check("abort_error", bus.error, 32'h0);
    tick();
    check("abort_busy", bus.busy, 32'h0);
    check("abort_upc", dut.r_upc, 32'd18);

    // Illegal entry address
    bus.decode_addr = 5'd30;
    bus.id_rf_valid_inst = 1'b1;
    settle();
    check("ill_error", bus.error, 32'h1);
    check("ill_rfvalid", bus.rf_valid_inst, 32'h1);
    check("ill_done", bus.done, 32'h0);
    check("ill_ctrl", bus.current_control, 32'h80000);
    tick();
    check("ill_after_busy", bus.busy, 32'h0);

    // JAL: four-step ALU sequence
    bus.decode_addr = 5'd14;
    settle();
    check("jal_c0_ctrl", bus.current_control, 32'h40010);
    tick();
    check("jal_c1_ctrl", bus.current_control, 32'h40020);
    tick();
    check("jal_c2_ctrl", bus.current_control, 32'h40040);
    check("jal_c2_done", bus.done, 32'h0);
    tick();
    check("jal_c3_ctrl", bus.current_control, 32'h48001);
    check("jal_c3_done", bus.done, 32'h1);
    tick();
    check("jal_end_busy", bus.busy, 32'h0);

    // Reset in the middle of a SW address phase discards it silently
    bus.decode_addr = 5'd2;
    bus.HREADY = 1'b0;
    tick();
    check("mid_busy", bus.busy, 32'h1);
    rst = 1'b0;
    settle();
    check("mid_rst_htrans", bus.HTRANS, 32'h0);
    check("mid_rst_hwrite", bus.HWRITE, 32'h0);
    check("mid_rst_busy", bus.busy, 32'h0);
    check("mid_rst_ctrl", bus.current_control, 32'h80000);
    tick();
    rst = 1'b1;
    bus.id_rf_valid_inst = 1'b0;
    bus.HREADY = 1'b1;
    settle();
    check("mid_rst_upc", dut.r_upc, 32'd18);
    check("mid_rst_idle", bus.busy, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
